// File: rtl/vmon_bus_byte_fifo.sv
// vmon_bus_byte_fifo
// Snoops bus writes to a single mailbox address, compacts the enabled byte
// lanes into an ordered byte stream and buffers them in a circular FIFO that
// drains one byte per cycle over a valid/ready handshake. Writes that do not
// fit in full are dropped whole and reported via a sticky flag and counter.
//
// Ports:
//   clk          - clock, rising edge
//   reset        - asynchronous active-low reset
//   addr/data    - bus write address and data
//   byte_en      - bus byte-lane enables
//   write_en     - bus write strobe
//   out_data     - byte at the FIFO head (valid while out_valid=1)
//   out_valid    - FIFO not empty
//   out_ready    - consumer accepts out_data
//   count        - bytes currently stored
//   overflow     - sticky: a write was dropped
//   drop_cnt     - dropped write count, saturating
//   clr_overflow - clears overflow and drop_cnt
module vmon_bus_byte_fifo #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR          = {ADDR_WIDTH{1'b0}},
  parameter bit                    LITTLE_ENDIAN = 1'b1,
  parameter int                    DEPTH         = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [DATA_WIDTH-1:0]     data,
  input  logic [DATA_WIDTH/8-1:0]   byte_en,
  input  logic                      write_en,
  output logic [7:0]                out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic [15:0]               drop_cnt,
  input  logic                      clr_overflow
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = $clog2(NB + 1);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;

  // Lanes rearranged into take-order so compaction is endian-agnostic.
  logic [NB-1:0] be_ord_s;
  logic [7:0]    byte_ord_s [NB];
  // Sized to a power of two so the NW-bit running index never exceeds it.
  logic [7:0]    comp_s [2**NW];
  logic [NW-1:0] nk_s;
  logic [CW-1:0] n_s;
  logic [CW-1:0] free_s;
  logic          capture_s, accept_s, drop_s, pop_s;

  for (genvar g = 0; g < NB; g++) begin : g_ord
    localparam int L = LITTLE_ENDIAN ? g : (NB - 1 - g);
    assign be_ord_s[g]   = byte_en[L];
    assign byte_ord_s[g] = data[8*L +: 8];
  end

  // Compact enabled lanes into consecutive slots; nk_s ends up as popcount.
  always_comb begin
    nk_s = {NW{1'b0}};
    for (int i = 0; i < 2**NW; i++) begin
      comp_s[i] = 8'h00;
    end
    for (int i = 0; i < NB; i++) begin
      if (be_ord_s[i]) begin
        comp_s[nk_s] = byte_ord_s[i];
        nk_s         = nk_s + NW'(1);
      end else begin
        nk_s = nk_s;
      end
    end
  end

  assign n_s       = CW'(nk_s);
  // Space is judged on the registered count; a same-cycle pop does not help.
  assign free_s    = CW'(DEPTH) - count_q;
  assign capture_s = write_en && (addr == ADDR) && (byte_en != {NB{1'b0}});
  assign accept_s  = capture_s && (free_s >= n_s);
  assign drop_s    = capture_s && !accept_s;
  assign pop_s     = (count_q != {CW{1'b0}}) && out_ready;

  // Next-state for pointers, occupancy and drop reporting.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    count_d    = count_q + (accept_s ? n_s : CW'(0)) - (pop_s ? CW'(1) : CW'(0));
    if (accept_s) begin
      wr_ptr_d = wr_ptr_q + n_s[PW-1:0];
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    // A drop in the same cycle as a clear takes precedence.
    if (drop_s) begin
      overflow_d = 1'b1;
      if (clr_overflow) begin
        drop_cnt_d = 16'd1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = 16'd0;
    end else begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q   <= {PW{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
      drop_cnt_q <= 16'd0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Byte storage; left unreset because count=0 already marks it empty.
  // Writes may straddle the wrap point since the index wraps at PW bits.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      for (int j = 0; j < NB; j++) begin
        if (CW'(j) < n_s) begin
          mem_q[wr_ptr_q + PW'(j)] <= comp_s[NW'(j)];
        end
      end
    end
  end

  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = (count_q != {CW{1'b0}});
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
